// File: rtl/window_2x2_to_raster.sv
// window_2x2_to_raster
// Collects one tile-row of 2x2 tiles into a pair of row buffers. It then
// replays the top row and the bottom row as a 1-pixel-per-beat raster stream.
// Filling and draining never overlap. Ready_in stays low for the whole drain.
module window_2x2_to_raster #(
   parameter int DATA_WIDHT = 32,
   parameter int IMG_WIDHT  = 220,
   parameter int IMG_HEIGHT = 220
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDHT-1:0] Data_In1,
   input  logic [DATA_WIDHT-1:0] Data_In2,
   input  logic [DATA_WIDHT-1:0] Data_In3,
   input  logic [DATA_WIDHT-1:0] Data_In4,
   input  logic                  Valid_in,
   output logic                  Ready_in,
   output logic [DATA_WIDHT-1:0] Data_Out,
   output logic                  Valid_Out,
   input  logic                  Ready_Out,
   output logic                  End_Line,
   output logic                  End_Frame
);

   localparam int TILES_X = IMG_WIDHT / 2;
   localparam int TILES_Y = IMG_HEIGHT / 2;
   localparam int TCOL_W  = (TILES_X > 1) ? $clog2(TILES_X) : 1;
   localparam int TROW_W  = (TILES_Y > 1) ? $clog2(TILES_Y) : 1;
   localparam int PX_W    = $clog2(IMG_WIDHT);

   localparam logic [TCOL_W-1:0] TCOL_LAST = TCOL_W'(TILES_X - 1);
   localparam logic [TROW_W-1:0] TROW_LAST = TROW_W'(TILES_Y - 1);
   localparam logic [PX_W-1:0]   PX_LAST   = PX_W'(IMG_WIDHT - 1);

   typedef enum logic [1:0] {
      FILL    = 2'd0,
      DRAIN_T = 2'd1,
      DRAIN_B = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [TCOL_W-1:0] tcol;
   logic [TROW_W-1:0] trow;
   logic [PX_W-1:0]   px;

   logic [DATA_WIDHT-1:0] top_buf [IMG_WIDHT];
   logic [DATA_WIDHT-1:0] bot_buf [IMG_WIDHT];

   logic            in_fire;
   logic            out_fire;
   logic            tcol_last;
   logic            trow_last;
   logic            px_last;
   logic [PX_W-1:0] wr_even;
   logic [PX_W-1:0] wr_odd;

   // Handshake qualifiers, end-of-count flags and the buffer column pair for the current tile
   always_comb begin
      in_fire   = Valid_in & Ready_in;
      out_fire  = Valid_Out & Ready_Out;
      tcol_last = (tcol == TCOL_LAST);
      trow_last = (trow == TROW_LAST);
      px_last   = (px == PX_LAST);
      wr_even   = PX_W'({tcol, 1'b0});
      wr_odd    = wr_even | PX_W'(1);
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= FILL;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake/output decode
   // End_Line and End_Frame depend only on state and counters, so they stay stable during a stall
   always_comb begin
      state_nxt = state;
      Ready_in  = 1'b0;
      Valid_Out = 1'b0;
      Data_Out  = '0;
      End_Line  = 1'b0;
      End_Frame = 1'b0;
      case (state)
         FILL: begin
            Ready_in = 1'b1;
            if (Valid_in && tcol_last) begin
               state_nxt = DRAIN_T;
            end
         end
         DRAIN_T: begin
            Valid_Out = 1'b1;
            Data_Out  = top_buf[px];
            End_Line  = px_last;
            if (Ready_Out && px_last) begin
               state_nxt = DRAIN_B;
            end
         end
         DRAIN_B: begin
            Valid_Out = 1'b1;
            Data_Out  = bot_buf[px];
            End_Line  = px_last;
            End_Frame = px_last & trow_last;
            if (Ready_Out && px_last) begin
               state_nxt = FILL;
            end
         end
         default: begin
            state_nxt = FILL;
         end
      endcase
   end

   // Tile column, tile row and output pixel counters
   always_ff @(posedge clk) begin
      if (!rst) begin
         tcol <= '0;
         trow <= '0;
         px   <= '0;
      end else begin
         if (in_fire) begin
            tcol <= tcol_last ? '0 : tcol + 1'b1;
            if (tcol_last) begin
               px <= '0;
            end
         end
         if (out_fire) begin
            px <= px_last ? '0 : px + 1'b1;
            if (px_last && (state == DRAIN_B)) begin
               trow <= trow_last ? '0 : trow + 1'b1;
            end
         end
      end
   end

   // Row buffer writes; contents are not reset, since every entry is rewritten before it is read
   always_ff @(posedge clk) begin
      if (in_fire) begin
         top_buf[wr_even] <= Data_In1;
         top_buf[wr_odd]  <= Data_In2;
         bot_buf[wr_even] <= Data_In3;
         bot_buf[wr_odd]  <= Data_In4;
      end
   end

endmodule
